fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
- Control unit that sequences the instruction-fetch stage and the pipeline behind it.
- Generates PC write enable, IF/ID write/flush and the global pipeline enable (db_ena).
- Arbitrates between debug commands (run/step/stop), hazard stalls and taken control transfers.
- Detects the halt instruction and drains the pipeline before freezing; sits between the debug unit, the hazard unit and instruction_fetch/IF_ID.

Parameters:
INSTR_W, 32, instruction width
HALT_INSTR, 32'hFFFF_FFFF, encoding that ends the program
DRAIN_CYCLES, 4, cycles the pipeline keeps advancing after halt detection (ID/EX/MEM/WB)
CNT_W, 32, width of the cycle counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
cmd_run  in  1  one-cycle pulse: continuous execution
cmd_step  in  1  one-cycle pulse: advance pipeline exactly one cycle
cmd_stop  in  1  one-cycle pulse: pause continuous execution
stall  in  1  load-use hazard from hazard unit
PC_Src  in  1  branch taken (beq/bne resolved in ID)
jump_any  in  1  jump|jal|jr|jalr active in ID
instr_in  in  INSTR_W  instruction currently output by instruction memory
PC_Wr  out  1  PC register enable
IF_ID_Wr  out  1  IF/ID register enable
IF_ID_flush  out  1  load bubble (NOP) into IF/ID
db_ena  out  1  enable for all pipeline registers except PC and IF/ID
halted  out  1  program finished, pipeline frozen
cycles  out  CNT_W  count of cycles with db_ena=1
state  out  3  current FSM state, for debug readout

Behaviour:
- States: IDLE=0, RUN=1, STEP=2, DRAIN=3, HALT=4. State, drain counter and cycles are registered; all enables are combinational from state and inputs.
- Reset (async, any time including mid-DRAIN):
  - state=IDLE, cycles=0, drain counter=0.
  - PC_Wr=IF_ID_Wr=IF_ID_flush=db_ena=halted=0.
- adv = (state==RUN)|(state==STEP)|(state==DRAIN).
- db_ena = adv. Stall does not gate db_ena; the hazard unit bubbles ID/EX itself.
- halt_hit = adv & (state!=DRAIN) & (instr_in==HALT_INSTR) & ~flush_cond.
- flush_cond = (PC_Src|jump_any) & ~stall.
- PC_Wr = adv & (state!=DRAIN) & ~stall & ~halt_hit. The PC freezes on the halt address in the same cycle the halt is detected.
- IF_ID_Wr = adv & ~stall.
- IF_ID_flush:
  - = 1 when adv & (flush_cond | halt_hit | state==DRAIN); otherwise 0.
  - Stall has priority over flush: with stall=1, flush=0 and PC_Wr=IF_ID_Wr=0.
- Transitions (evaluated at the rising edge):
  - IDLE:
    - cmd_run -> RUN.
    - else cmd_step -> STEP.
    - Simultaneous run+step: run wins. cmd_stop ignored.
  - RUN:
    - halt_hit -> DRAIN, drain counter loaded with DRAIN_CYCLES-1.
    - else cmd_stop -> IDLE.
    - Halt beats stop. cmd_run/cmd_step ignored.
  - STEP: lasts exactly one cycle.
    - halt_hit -> DRAIN.
    - else -> IDLE.
  - DRAIN:
    - Counter decrements each cycle; at counter==0 -> HALT.
    - All commands ignored.
    - Exactly DRAIN_CYCLES cycles with db_ena=1 after the detection cycle.
  - HALT: halted=1, all enables 0. Only reset exits.
- cycles:
  - +1 on every clock with db_ena=1, including the halt-detection cycle and DRAIN cycles.
  - Saturates at all-ones (no wrap).
- Step while stall=1: the cycle is consumed (db_ena=1, PC held); the user steps again.
- A halt instruction sitting behind a taken branch/jump (flush_cond=1) is squashed and does not trigger halt.

Decomposition:
- Shared package/header: state encodings (ST_IDLE..ST_HALT), HALT_INSTR default, NOP encoding (32'h0) used by IF_ID flush.
- One natural sub-module: drain_counter, a loadable down-counter with a zero flag. The FSM and enable logic stay in fetch_sequencer.

Test Plan:
- Reset then idle 5 cycles -> state=0, PC_Wr=0, db_ena=0, cycles=0. Assert reset mid-RUN -> all outputs 0 immediately, without waiting for a clock edge.
- cmd_step pulse three times, non-halt instr_in, stall=0 -> three single cycles with PC_Wr=1, state returns to 0 each time, cycles=3.
- cmd_run, stall=1 for 2 cycles then 0 -> PC_Wr=IF_ID_Wr=0 for those 2 cycles, db_ena=1 throughout, cycles keeps incrementing.
- RUN with PC_Src=1 and stall=0 -> IF_ID_flush=1, PC_Wr=1. Same cycle with stall=1 -> IF_ID_flush=0, PC_Wr=0.
- RUN, instr_in=32'hFFFF_FFFF at cycle N -> PC_Wr=0 at N, state=3 for exactly 4 cycles with db_ena=1 and IF_ID_flush=1, then state=4, halted=1, cycles=N_count+5. cmd_run afterwards has no effect.
- HALT_INSTR arriving with jump_any=1 -> no halt, state stays RUN. cmd_run with cmd_step simultaneous from IDLE -> RUN. cmd_stop with halt_hit in the same cycle -> DRAIN.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: FSM state encodings, default
// halt/NOP encodings and a helper that sizes the drain counter.
package fetch_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_STEP  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  localparam logic [31:0] HALT_INSTR_DEF   = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam int          DRAIN_CYCLES_DEF = 4;

  // A counter that must hold values 0..n-1 needs at least one bit.
  function automatic int drain_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fetch_sequencer_drain_counter.sv
// Loadable down-counter with a zero flag; counts the cycles the pipeline keeps
// advancing after a halt instruction is detected.
module fetch_sequencer_drain_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic [W-1:0] o_count,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge values; blocking = here would create order-dependent races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: arbitrates debug run/step/stop, hazard stalls and taken
// control transfers, and drains the pipeline after the halt instruction.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int                 INSTR_W      = 32,
  parameter logic [INSTR_W-1:0] HALT_INSTR   = INSTR_W'(HALT_INSTR_DEF),
  parameter int                 DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int                 CNT_W        = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_run,
  input  logic               cmd_step,
  input  logic               cmd_stop,
  input  logic               stall,
  input  logic               PC_Src,
  input  logic               jump_any,
  input  logic [INSTR_W-1:0] instr_in,
  output logic               PC_Wr,
  output logic               IF_ID_Wr,
  output logic               IF_ID_flush,
  output logic               db_ena,
  output logic               halted,
  output logic [CNT_W-1:0]   cycles,
  output logic [2:0]         state
);

  localparam int DRAIN_W = drain_width(DRAIN_CYCLES);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cycles;

  logic               w_adv;
  logic               w_in_drain;
  logic               w_flush_cond;
  logic               w_halt_hit;
  logic               w_drain_load;
  logic               w_drain_zero;
  logic [DRAIN_W-1:0] w_drain_count;

  assign w_adv        = (r_state == ST_RUN) || (r_state == ST_STEP) || (r_state == ST_DRAIN);
  assign w_in_drain   = (r_state == ST_DRAIN);
  assign w_flush_cond = (PC_Src | jump_any) & ~stall;

  // A halt word sitting behind a taken branch/jump is squashed, not executed.
  assign w_halt_hit   = w_adv & ~w_in_drain & (instr_in == HALT_INSTR) & ~w_flush_cond;
  assign w_drain_load = w_halt_hit;

  // Enables are combinational so a stall or redirect acts in the same cycle.
  assign db_ena      = w_adv;
  assign PC_Wr       = w_adv & ~w_in_drain & ~stall & ~w_halt_hit;
  assign IF_ID_Wr    = w_adv & ~stall;
  assign IF_ID_flush = w_adv & ~stall & (w_flush_cond | w_halt_hit | w_in_drain);
  assign halted      = (r_state == ST_HALT);
  assign cycles      = r_cycles;
  assign state       = r_state;

  fetch_sequencer_drain_counter #(
    .W (DRAIN_W)
  ) u_drain_counter (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_drain_load),
    .i_load_val (DRAIN_W'(DRAIN_CYCLES - 1)),
    .i_dec      (w_in_drain),
    .o_count    (w_drain_count),
    .o_zero     (w_drain_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_run) begin
            r_state <= ST_RUN;
          end else if (cmd_step) begin
            r_state <= ST_STEP;
          end
        end
        ST_RUN: begin
          if (w_halt_hit) begin
            r_state <= ST_DRAIN;
          end else if (cmd_stop) begin
            r_state <= ST_IDLE;
          end
        end
        ST_STEP: begin
          r_state <= w_halt_hit ? ST_DRAIN : ST_IDLE;
        end
        ST_DRAIN: begin
          if (w_drain_zero) begin
            r_state <= ST_HALT;
          end
        end
        ST_HALT: begin
          r_state <= ST_HALT;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Counts every cycle the pipeline advances; saturates instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cycles <= '0;
    end else if (w_adv && (r_cycles != {CNT_W{1'b1}})) begin
      r_cycles <= r_cycles + CNT_W'(1);
    end
  end

endmodule
